// File: rtl/phase_scheduler.sv
// Demand-actuated two-road phase scheduler: PG rests until a secondary or pedestrian call,
// then runs PY/AR1/SG/SY/AR2, timing every phase in 1 Hz ticks from the register-bank values.
module phase_scheduler #(
  parameter int unsigned ALLRED = 2,
  parameter int unsigned FLASH  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic [6:0] Tpv,
  input  logic [6:0] Tsv,
  input  logic [6:0] Ta,
  input  logic       sec_car,
  input  logic       ped_req_p,
  output logic [2:0] Principal_Road,
  output logic [2:0] Secondary_Road,
  output logic [1:0] Principal_Pedestrian,
  output logic [1:0] Secondary_Pedestrian,
  output logic [1:0] MuxSel,
  output logic [6:0] timeRemaining,
  output logic [2:0] StateFlag
);

  typedef enum logic [2:0] {
    PG  = 3'd0,
    PY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } state_e;

  localparam logic [6:0] ALLRED_LD = (ALLRED == 0) ? 7'd1 : 7'(ALLRED);
  localparam logic [6:0] FLASH_LD  = 7'(FLASH);

  state_e     state_q, state_d, nxt;
  logic [6:0] cnt_q, cnt_d;
  logic       ext_q, ext_d;
  logic       sec_call_q, sec_call_d;
  logic       blink_q, blink_d;
  logic       demand, expire, window, advance;
  logic [6:0] tpv_ld, tsv_ld, ta_ld, nxt_ld;
  logic [1:0] walk;

  function automatic logic [6:0] at_least_1(input logic [6:0] v);
    return (v == 7'd0) ? 7'd1 : v;
  endfunction

  assign tpv_ld = at_least_1(Tpv);
  assign tsv_ld = at_least_1(Tsv);
  assign ta_ld  = at_least_1(Ta);

  assign demand = sec_call_q | sec_car | ped_req_p;
  assign expire = (cnt_q <= 7'd1);
  // Pedestrian flash window: PG extension, or the last FLASH ticks of SG.
  assign window = (state_q == PG) ? ext_q
                : ((state_q == SG) && (cnt_q != 7'd0) && (cnt_q <= FLASH_LD));

  always_comb begin
    nxt    = PG;
    nxt_ld = tpv_ld;
    case (state_q)
      PG:      begin nxt = PY;  nxt_ld = ta_ld;     end
      PY:      begin nxt = AR1; nxt_ld = ALLRED_LD; end
      AR1:     begin nxt = SG;  nxt_ld = tsv_ld;    end
      SG:      begin nxt = SY;  nxt_ld = ta_ld;     end
      SY:      begin nxt = AR2; nxt_ld = ALLRED_LD; end
      default: begin nxt = PG;  nxt_ld = tpv_ld;    end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ext_d      = ext_q;
    blink_d    = blink_q;
    sec_call_d = sec_call_q | sec_car | ped_req_p;
    advance    = 1'b0;
    if (tick) begin
      if (!expire) begin
        cnt_d = cnt_q - 7'd1;
        if (window) blink_d = ~blink_q;
      end else if (state_q == PG && !ext_q) begin
        // Counter 0 means resting; a demand seen on any tick starts the flash extension.
        if (!demand)                cnt_d = 7'd0;
        else if (FLASH_LD != 7'd0) begin
          ext_d = 1'b1;
          cnt_d = FLASH_LD;
        end else                    advance = 1'b1;
      end else begin
        advance = 1'b1;
      end
    end
    if (advance) begin
      state_d = nxt;
      cnt_d   = nxt_ld;
      ext_d   = 1'b0;
      blink_d = 1'b0;
      if (nxt == SG) sec_call_d = sec_car | ped_req_p;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= PG;
      cnt_q      <= tpv_ld;
      ext_q      <= 1'b0;
      sec_call_q <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ext_q      <= ext_d;
      sec_call_q <= sec_call_d;
      blink_q    <= blink_d;
    end
  end

  assign walk = window ? (blink_q ? 2'b00 : 2'b10) : 2'b01;

  always_comb begin
    Principal_Road       = 3'b100;
    Secondary_Road       = 3'b100;
    Principal_Pedestrian = 2'b10;
    Secondary_Pedestrian = 2'b10;
    MuxSel               = 2'b11;
    case (state_q)
      PG: begin
        Principal_Road       = 3'b001;
        Secondary_Pedestrian = walk;
        MuxSel               = ext_q ? 2'b11 : 2'b00;
      end
      PY: begin
        Principal_Road = 3'b010;
        MuxSel         = 2'b10;
      end
      SG: begin
        Secondary_Road       = 3'b001;
        Principal_Pedestrian = walk;
        MuxSel               = 2'b01;
      end
      SY: begin
        Secondary_Road = 3'b010;
        MuxSel         = 2'b10;
      end
      default: MuxSel = 2'b11;
    endcase
  end

  assign timeRemaining = cnt_q;
  assign StateFlag     = state_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Bench for phase_scheduler: directed scenarios plus random traffic, each cycle compared
// against a phase-level reference model.
module tb_phase_scheduler;
  localparam int ALLRED = 2;
  localparam int FLASH  = 3;

  logic       clock = 1'b0;
  logic       reset, tick, sec_car, ped_req_p;
  logic [6:0] Tpv, Tsv, Ta;
  logic [2:0] Principal_Road, Secondary_Road, StateFlag;
  logic [1:0] Principal_Pedestrian, Secondary_Pedestrian, MuxSel;
  logic [6:0] timeRemaining;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase index 0..5, ticks remaining, flash-extension flag, call, blink.
  int m_ph, m_rem;
  bit m_ext, m_call, m_blink;

  phase_scheduler #(.ALLRED(ALLRED), .FLASH(FLASH)) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .Tpv(Tpv), .Tsv(Tsv), .Ta(Ta),
    .sec_car(sec_car), .ped_req_p(ped_req_p),
    .Principal_Road(Principal_Road), .Secondary_Road(Secondary_Road),
    .Principal_Pedestrian(Principal_Pedestrian), .Secondary_Pedestrian(Secondary_Pedestrian),
    .MuxSel(MuxSel), .timeRemaining(timeRemaining), .StateFlag(StateFlag)
  );

  always #5 clock = ~clock;

  function automatic int dur(input int ph);
    int d;
    case (ph)
      0:       d = int'(Tpv);
      1, 4:    d = int'(Ta);
      3:       d = int'(Tsv);
      default: d = ALLRED;
    endcase
    return (d == 0) ? 1 : d;
  endfunction

  function automatic bit in_window();
    return (m_ph == 0 && m_ext) || (m_ph == 3 && m_rem >= 1 && m_rem <= FLASH);
  endfunction

  task automatic model_step();
    bit dem, win;
    if (reset) begin
      m_ph = 0; m_rem = dur(0); m_ext = 0; m_call = 0; m_blink = 0;
      return;
    end
    dem    = m_call | sec_car | ped_req_p;
    win    = in_window();
    m_call = dem;
    if (tick) begin
      if (m_rem > 1) begin
        m_rem--;
        if (win) m_blink = !m_blink;
      end else if (m_ph == 0 && !m_ext && !dem) begin
        m_rem = 0;
      end else if (m_ph == 0 && !m_ext && FLASH > 0) begin
        m_ext = 1; m_rem = FLASH;
      end else begin
        m_ph    = (m_ph + 1) % 6;
        m_ext   = 0;
        m_blink = 0;
        m_rem   = dur(m_ph);
        if (m_ph == 3) m_call = sec_car | ped_req_p;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [2:0] pr, sr;
    logic [1:0] walk, pp, sp, ms;
    walk = in_window() ? (m_blink ? 2'b00 : 2'b10) : 2'b01;
    pr = (m_ph == 0) ? 3'b001 : (m_ph == 1) ? 3'b010 : 3'b100;
    sr = (m_ph == 3) ? 3'b001 : (m_ph == 4) ? 3'b010 : 3'b100;
    sp = (m_ph == 0) ? walk : 2'b10;
    pp = (m_ph == 3) ? walk : 2'b10;
    case (m_ph)
      0:       ms = m_ext ? 2'b11 : 2'b00;
      1, 4:    ms = 2'b10;
      3:       ms = 2'b01;
      default: ms = 2'b11;
    endcase
    chk("state",   8'(StateFlag), 8'(m_ph));
    chk("time",    8'(timeRemaining), 8'(m_rem));
    chk("p_road",  8'(Principal_Road), 8'(pr));
    chk("s_road",  8'(Secondary_Road), 8'(sr));
    chk("p_ped",   8'(Principal_Pedestrian), 8'(pp));
    chk("s_ped",   8'(Secondary_Pedestrian), 8'(sp));
    chk("muxsel",  8'(MuxSel), 8'(ms));
    chk("one_red", 8'(Principal_Road[2] | Secondary_Road[2]), 8'd1);
  endtask

  task automatic cyc(input bit t);
    tick = t;
    @(posedge clock);
    model_step();
    #1;
    check_outputs();
    tick = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1); cyc(1'b0); cyc(1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b1);
    cyc(1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; sec_car = 1'b0; ped_req_p = 1'b0;
    Tpv = 7'd10; Tsv = 7'd5; Ta = 7'd3;

    // Reset values and rest in PG without demand.
    do_reset();
    chk("rst_state", 8'(StateFlag), 8'd0);
    chk("rst_time", 8'(timeRemaining), 8'd10);
    chk("rst_sped", 8'(Secondary_Pedestrian), 8'b01);
    chk("rst_pped", 8'(Principal_Pedestrian), 8'b10);
    chk("rst_mux", 8'(MuxSel), 8'd0);
    tick_n(9);
    chk("pg_last", 8'(timeRemaining), 8'd1);
    tick_n(21);
    chk("rest_state", 8'(StateFlag), 8'd0);
    chk("rest_time", 8'(timeRemaining), 8'd0);
    chk("rest_walk", 8'(Secondary_Pedestrian), 8'b01);

    // Pedestrian pulse between ticks while resting.
    ped_req_p = 1'b1; cyc(1'b0); ped_req_p = 1'b0; cyc(1'b0);
    cyc(1'b1);
    chk("ped_flash_ld", 8'(timeRemaining), 8'd3);
    chk("ped_flash_mux", 8'(MuxSel), 8'b11);
    cyc(1'b0); cyc(1'b0);
    tick_n(2);
    cyc(1'b1);
    chk("ped_to_py", 8'(StateFlag), 8'd1);
    cyc(1'b0); cyc(1'b0);

    // Secondary car pulse on tick 4 of a fresh PG; full cycle back to PG.
    do_reset();
    tick_n(3);
    sec_car = 1'b1; cyc(1'b1); sec_car = 1'b0; cyc(1'b0); cyc(1'b0);
    tick_n(5);
    chk("car_pg1", 8'(timeRemaining), 8'd1);
    tick_n(1);
    chk("car_ext", 8'(timeRemaining), 8'd3);
    chk("car_ext_mux", 8'(MuxSel), 8'b11);
    tick_n(3);
    chk("car_py", 8'(StateFlag), 8'd1);
    tick_n(3);
    chk("car_ar1", 8'(StateFlag), 8'd2);
    tick_n(2);
    chk("car_sg", 8'(timeRemaining), 8'd5);
    tick_n(2);
    chk("sg_flash1", 8'(Principal_Pedestrian), 8'b10);
    tick_n(1);
    chk("sg_flash2", 8'(Principal_Pedestrian), 8'b00);
    tick_n(2);
    chk("car_sy", 8'(StateFlag), 8'd4);
    tick_n(3);
    chk("car_ar2", 8'(StateFlag), 8'd5);
    tick_n(2);
    chk("car_back_pg", 8'(timeRemaining), 8'd10);

    // Zero Tsv/Ta load as one tick, nothing skipped.
    Tpv = 7'd2; Tsv = 7'd0; Ta = 7'd0;
    do_reset();
    sec_car = 1'b1; cyc(1'b0); sec_car = 1'b0;
    tick_n(1 + 1 + 3);
    chk("z_py", 8'(StateFlag), 8'd1);
    chk("z_py_t", 8'(timeRemaining), 8'd1);
    tick_n(1);
    chk("z_ar1", 8'(StateFlag), 8'd2);
    tick_n(2);
    chk("z_sg", 8'(StateFlag), 8'd3);
    chk("z_sg_t", 8'(timeRemaining), 8'd1);
    tick_n(1);
    chk("z_sy", 8'(StateFlag), 8'd4);
    tick_n(1);
    chk("z_ar2", 8'(StateFlag), 8'd5);
    tick_n(2);
    chk("z_pg", 8'(StateFlag), 8'd0);

    // Tpv changed mid-phase takes effect only on the next PG entry.
    Tpv = 7'd10; Tsv = 7'd5; Ta = 7'd3;
    do_reset();
    tick_n(5);
    Tpv = 7'd4;
    tick_n(4);
    chk("tpv_hold", 8'(timeRemaining), 8'd1);
    ped_req_p = 1'b1; cyc(1'b0); ped_req_p = 1'b0;
    tick_n(1 + 3 + 15);
    chk("tpv_new_st", 8'(StateFlag), 8'd0);
    chk("tpv_new", 8'(timeRemaining), 8'd4);

    // Reset in SG at counter 2, secondary car held high.
    Tpv = 7'd3;
    sec_car = 1'b1;
    begin
      int budget = 300;
      while (!(m_ph == 3 && m_rem == 2) && budget > 0) begin
        cyc(budget % 3 == 0);
        budget--;
      end
      chk("reach_sg2", 8'(budget > 0), 8'd1);
    end
    reset = 1'b1; cyc(1'b1); reset = 1'b0;
    chk("mid_rst_state", 8'(StateFlag), 8'd0);
    chk("mid_rst_time", 8'(timeRemaining), 8'd3);
    chk("mid_rst_road", 8'(Secondary_Road), 8'b100);
    begin
      int budget = 200;
      while (StateFlag != 3'd3 && budget > 0) begin
        cyc(budget % 3 == 0);
        budget--;
      end
      chk("re_request", 8'(StateFlag), 8'd3);
    end
    sec_car = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) Tpv = 7'($urandom_range(0, 8));
      if ($urandom_range(0, 99) == 0) Tsv = 7'($urandom_range(0, 8));
      if ($urandom_range(0, 99) == 0) Ta  = 7'($urandom_range(0, 5));
      sec_car   = ($urandom_range(0, 24) == 0);
      ped_req_p = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 2) == 0);
    end
    reset = 1'b0; sec_car = 1'b0; ped_req_p = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/phase_scheduler.md
# phase_scheduler

Demand-actuated phase scheduler for the two-road intersection. It sequences the principal/secondary road and pedestrian lights, and times each phase from the Tpv/Tsv/Ta register-bank values. The principal road rests in green until a secondary vehicle or a principal-crossing pedestrian calls, with an all-red clearance between directions. It sits between the register bank and the light drivers and replaces fixed-cycle sequencing; the 1 Hz tick arrives as a single-cycle enable in the `clock` domain.

## Interface
- ALLRED, 2: all-red clearance length, in ticks (≥1).
- FLASH, 3: pedestrian flashing-warning length at the end of a walk phase, in ticks (< any programmed green).
- clock  in  1  system clock; only clock in the block.
- reset  in  1  synchronous, active-high.
- tick  in  1  one-`clock`-cycle pulse at 1 Hz; the only time base.
- Tpv, Tsv, Ta  in  7 each  principal green, secondary green and yellow durations, in ticks.
- sec_car  in  1  secondary-road vehicle sensor (level).
- ped_req_p  in  1  button to cross the principal road (pulse or level).
- Principal_Road, Secondary_Road  out  3  {red, yellow, green}, one-hot.
- Principal_Pedestrian, Secondary_Pedestrian  out  2  {dont_walk, walk}.
- MuxSel  out  2  timing source of the current phase: 00 Tpv, 01 Tsv, 10 Ta, 11 fixed (all-red or flash extension).
- timeRemaining  out  7  current phase counter.
- StateFlag  out  3  PG=0, PY=1, AR1=2, SG=3, SY=4, AR2=5.

## Operation
- States: PG → PY → AR1 → SG → SY → AR2 → PG.
- Load values on phase entry:
  - PG: Tpv
  - PY, SY: Ta
  - AR1, AR2: ALLRED
  - SG: Tsv
- A loaded value of 0 is treated as 1. Inputs are sampled only at load; changing Tpv/Tsv/Ta mid-phase has no effect until the next entry.
- Counting happens on tick cycles only:
  - if counter ≤ 1: phase expires;
  - else: counter − 1.
  - Each phase therefore lasts exactly its loaded value, in ticks.
- Demand = sec_call | sec_car | ped_req_p.
  - sec_call is a sticky flag, set on any cycle where sec_car or ped_req_p is high.
  - sec_call is cleared on entry to SG. A request arriving in that same cycle wins: it is re-set.
- PG expiry:
  - With demand: load FLASH. The remaining PG time is the pedestrian flash. At that expiry, go to PY.
  - Without demand: enter rest. Counter = 0, stay in PG with steady walk.
  - In rest, the first tick seeing demand loads FLASH, using the same path as above.
  - If FLASH=0, go directly to PY.
- PG then expires to PY only after the flash extension. Track this with an internal bit `ext`; MuxSel=11 while ext=1.
- SG expiry goes to SY. SG has no rest state.
- Light outputs per state:
  - PG: road 001/100; Secondary_Pedestrian walk, Principal_Pedestrian 10.
  - PY: 010/100.
  - AR1 and AR2: 100/100.
  - SG: 100/001; Principal_Pedestrian walk.
  - SY: 100/010.
  - Any pedestrian not in walk shows 10.
- Walk and flash:
  - Walk = 01.
  - During the flash window, the walk output alternates 10/00 on each tick, driven by a `blink` flop.
  - PG flash window: ext=1.
  - SG flash window: 1 ≤ counter ≤ FLASH.
  - blink is cleared on every phase entry.
- Reset (at any time, including mid-phase) takes effect at the next clock edge:
  - state=PG, counter=max(Tpv,1), ext=0, sec_call=0, blink=0.
  - Outputs 001/100, Secondary_Pedestrian=01, Principal_Pedestrian=10, MuxSel=00, StateFlag=0.

## Timing
- All outputs are registered, or decoded from registered state and counter only. The design is glitch-free per clock.
- A phase transition takes effect at the clock edge of the expiring tick cycle. The new state and its load value are visible the next cycle.
- A demand input high in the same cycle as PG expiry counts as demand. No extra tick is needed.
- The tick input is ignored while reset is high.
- Between any green and any opposing green there are at least Ta + ALLRED ticks. Both roads are never simultaneously non-red.

## Test plan
- Reset with Tpv=10, Ta=3, Tsv=5, no demand; run 30 ticks:
  - required: StateFlag=0 throughout;
  - timeRemaining goes 10…1, then holds at 0;
  - Secondary_Pedestrian stays steady 01.
- Pulse sec_car at tick 4 with Tpv=10:
  - required: PG lasts 10+3 ticks, flashing for the last 3;
  - then PY 3, AR1 2, SG 5 (Principal_Pedestrian flashes over ticks 3..1), SY 3, AR2 2, and back to PG with timeRemaining=10.
- In rest (counter 0), assert ped_req_p for one cycle between ticks:
  - required: the next tick loads 3 with MuxSel=11;
  - PY follows 3 ticks later.
- Tsv=0, Ta=0:
  - required: SG, PY and SY each last exactly 1 tick;
  - no state is skipped.
- Change Tpv from 10 to 4 midway through PG:
  - required: the current PG still counts to 1 from 10;
  - the next PG loads 4.
- Assert reset during SG with counter 2:
  - required: the next cycle shows the full reset values above and sec_call=0;
  - a sec_car held high re-requests a secondary phase.
